// File: rtl/uart_avm_pkg.sv
// Shared types and register map for the UART Avalon-MM arbiter.
package uart_avm_pkg;

    localparam logic [4:0] RX_BASE     = 5'h0;
    localparam logic [4:0] TX_BASE     = 5'h4;
    localparam logic [4:0] STATUS_BASE = 5'h8;
    localparam int         RRDY_BIT    = 7;
    localparam int         TRDY_BIT    = 6;

    typedef enum logic [1:0] {IDLE, POLL, XFER} state_e;
    typedef enum logic {G_TX = 1'b0, G_RX = 1'b1} grant_e;

    function automatic grant_e other_client(grant_e g);
        return (g == G_TX) ? G_RX : G_TX;
    endfunction

endpackage

// File: rtl/uart_avm_arbiter_rr_pick2.sv
// Two-way round-robin pick: the pointer breaks ties, a lone requester always wins.
module rr_pick2
    import uart_avm_pkg::*;
(
    input  logic [1:0] req_i,
    input  grant_e     ptr_i,
    output grant_e     grant_o,
    output logic       any_o
);

    always_comb begin
        any_o   = |req_i;
        grant_o = ptr_i;
        if (req_i == 2'b01)
            grant_o = G_TX;
        else if (req_i == 2'b10)
            grant_o = G_RX;
    end

endmodule

// File: rtl/uart_avm_arbiter.sv
// Shares one Avalon-MM master to the UART between a TX byte client and an RX byte client,
// polling the status register before each data access.
module uart_avm_arbiter
    import uart_avm_pkg::*;
(
    input  logic        avm_clk,
    input  logic        avm_rst,
    output logic [4:0]  avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest,
    input  logic        tx_req,
    input  logic [7:0]  tx_data,
    output logic        tx_ack,
    input  logic        rx_req,
    output logic [7:0]  rx_data,
    output logic        rx_valid
);

    state_e     state_q, state_d;
    grant_e     gnt_q, gnt_d;
    grant_e     ptr_q, ptr_d;
    logic [7:0] wbyte_q, wbyte_d;
    logic       tx_ack_q, tx_ack_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_data_q, rx_data_d;

    grant_e     pick_gnt;
    logic       pick_any;
    logic       tx_elig, rx_elig;
    logic       ready_bit;
    logic       unused_rd;

    assign unused_rd = ^avm_readdata[31:8];

    // A client is skipped only in the cycle its completion pulse is visible.
    assign tx_elig = tx_req & ~tx_ack_q;
    assign rx_elig = rx_req & ~rx_valid_q;

    rr_pick2 u_pick (
        .req_i   ({rx_elig, tx_elig}),
        .ptr_i   (ptr_q),
        .grant_o (pick_gnt),
        .any_o   (pick_any)
    );

    assign ready_bit = (gnt_q == G_TX) ? avm_readdata[TRDY_BIT] : avm_readdata[RRDY_BIT];

    always_comb begin
        avm_address = '0;
        avm_read    = 1'b0;
        avm_write   = 1'b0;
        case (state_q)
            POLL: begin
                avm_address = STATUS_BASE;
                avm_read    = 1'b1;
            end
            XFER: begin
                if (gnt_q == G_TX) begin
                    avm_address = TX_BASE;
                    avm_write   = 1'b1;
                end else begin
                    avm_address = RX_BASE;
                    avm_read    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign avm_writedata = {24'b0, wbyte_q};
    assign tx_ack        = tx_ack_q;
    assign rx_valid      = rx_valid_q;
    assign rx_data       = rx_data_q;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
        wbyte_d    = wbyte_q;
        tx_ack_d   = 1'b0;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = POLL;
                    gnt_d   = pick_gnt;
                end
            end
            POLL: begin
                if (!avm_waitrequest) begin
                    if (ready_bit) begin
                        state_d = XFER;
                        if (gnt_q == G_TX)
                            wbyte_d = tx_data;
                    end else begin
                        state_d = IDLE;
                        ptr_d   = other_client(gnt_q);
                    end
                end
            end
            XFER: begin
                if (!avm_waitrequest) begin
                    state_d = IDLE;
                    ptr_d   = other_client(gnt_q);
                    if (gnt_q == G_TX) begin
                        tx_ack_d = 1'b1;
                    end else begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = avm_readdata[7:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge avm_clk) begin
        if (!avm_rst) begin
            state_q    <= IDLE;
            gnt_q      <= G_TX;
            ptr_q      <= G_TX;
            wbyte_q    <= '0;
            tx_ack_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            wbyte_q    <= wbyte_d;
            tx_ack_q   <= tx_ack_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

endmodule

// File: tb/tb_uart_avm_arbiter.sv
// Directed bench for uart_avm_arbiter: emulated UART slave, transaction-level model, per-cycle compare.
module tb_uart_avm_arbiter;

    logic        clk = 1'b0;
    logic        avm_rst;
    logic [4:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic        tx_req;
    logic [7:0]  tx_data;
    logic        tx_ack;
    logic        rx_req;
    logic [7:0]  rx_data;
    logic        rx_valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_avm_arbiter dut (
        .avm_clk         (clk),
        .avm_rst         (avm_rst),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .tx_req          (tx_req),
        .tx_data         (tx_data),
        .tx_ack          (tx_ack),
        .rx_req          (rx_req),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid)
    );

    // ---------------- UART slave emulation ----------------
    logic [31:0] status_val;
    logic [31:0] rx_reg;
    int          nr_polls;
    int          stall_cfg;
    int          cnt;
    int          st_reads, wr_cnt, ack_cnt;
    int          ord[$];

    assign avm_waitrequest = (avm_read | avm_write) && (cnt != 0);
    assign avm_readdata    = (avm_address == 5'h8) ? ((st_reads < nr_polls) ? 32'h0 : status_val) : rx_reg;

    always @(posedge clk) begin
        if (!(avm_read | avm_write))
            cnt <= stall_cfg;
        else if (cnt != 0)
            cnt <= cnt - 1;
        else
            cnt <= stall_cfg;
        if (!avm_rst) begin
            st_reads <= 0;
            wr_cnt   <= 0;
            ack_cnt  <= 0;
        end else begin
            if (avm_read && avm_address == 5'h8 && !avm_waitrequest) st_reads <= st_reads + 1;
            if (avm_write && !avm_waitrequest) wr_cnt <= wr_cnt + 1;
            if (tx_ack) ack_cnt <= ack_cnt + 1;
        end
    end

    // ---------------- transaction-level model ----------------
    // owner: -1 none, 0 TX, 1 RX; phase 1 = status poll, 2 = data access
    int         m_own = -1;
    int         m_ph = 0;
    int         m_prio = 0;
    bit         m_ack = 0, m_val = 0;
    logic [7:0] m_rxd = 8'h0, m_wb = 8'h0;

    always @(posedge clk) begin : model
        bit e0, e1;
        if (!avm_rst) begin
            m_own <= -1; m_ph <= 0; m_prio <= 0;
            m_ack <= 0; m_val <= 0; m_rxd <= 8'h0; m_wb <= 8'h0;
        end else begin
            m_ack <= 0;
            m_val <= 0;
            if (m_own < 0) begin
                e0 = tx_req && !m_ack;
                e1 = rx_req && !m_val;
                m_ph <= 1;
                if (e0 && e1)  m_own <= m_prio;
                else if (e0)   m_own <= 0;
                else if (e1)   m_own <= 1;
            end else if (!avm_waitrequest) begin
                if (m_ph == 1) begin
                    if (avm_readdata[(m_own == 0) ? 6 : 7]) begin
                        m_ph <= 2;
                        if (m_own == 0) m_wb <= tx_data;
                    end else begin
                        m_own  <= -1;
                        m_prio <= 1 - m_own;
                    end
                end else begin
                    if (m_own == 0) m_ack <= 1;
                    else begin m_val <= 1; m_rxd <= avm_readdata[7:0]; end
                    m_own  <= -1;
                    m_prio <= 1 - m_own;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    bit chk_en = 0;

    always @(negedge clk) begin : compare
        logic [4:0] ea;
        bit er, ew;
        if (!avm_rst) ord.delete();
        else begin
            if (tx_ack)   ord.push_back(0);
            if (rx_valid) ord.push_back(1);
        end
        if (chk_en) begin
            ea = (m_own < 0) ? 5'h0 : (m_ph == 1) ? 5'h8 : (m_own == 0) ? 5'h4 : 5'h0;
            er = (m_own >= 0) && (m_ph == 1 || m_own == 1);
            ew = (m_own == 0) && (m_ph == 2);
            chk("mdl_address", {27'b0, avm_address}, {27'b0, ea});
            chk("mdl_read", {31'b0, avm_read}, {31'b0, er});
            chk("mdl_write", {31'b0, avm_write}, {31'b0, ew});
            chk("mdl_writedata", avm_writedata, {24'b0, m_wb});
            chk("mdl_tx_ack", {31'b0, tx_ack}, {31'b0, m_ack});
            chk("mdl_rx_valid", {31'b0, rx_valid}, {31'b0, m_val});
            chk("mdl_rx_data", {24'b0, rx_data}, {24'b0, m_rxd});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tx_req = 0; rx_req = 0; avm_rst = 0;
        tick(); tick();
        avm_rst = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        avm_rst = 0; tx_req = 0; rx_req = 0; tx_data = 8'h0;
        status_val = 32'h0; rx_reg = 32'h0; nr_polls = 0; stall_cfg = 0;
        cnt = 0; st_reads = 0; wr_cnt = 0; ack_cnt = 0;

        // reset state
        tick();
        chk_en = 1;
        chk("rst_address", {27'b0, avm_address}, 32'h0);
        chk("rst_read", {31'b0, avm_read}, 32'h0);
        chk("rst_write", {31'b0, avm_write}, 32'h0);
        chk("rst_writedata", avm_writedata, 32'h0);
        chk("rst_tx_ack", {31'b0, tx_ack}, 32'h0);
        chk("rst_rx_valid", {31'b0, rx_valid}, 32'h0);
        chk("rst_rx_data", {24'b0, rx_data}, 32'h0);
        tick();
        avm_rst = 1;

        // TX only, zero wait
        status_val = 32'h40; tx_data = 8'hA5; tx_req = 1;
        tick();
        chk("tx_c1_addr", {27'b0, avm_address}, 32'h8);
        chk("tx_c1_read", {31'b0, avm_read}, 32'h1);
        tick();
        chk("tx_c2_addr", {27'b0, avm_address}, 32'h4);
        chk("tx_c2_write", {31'b0, avm_write}, 32'h1);
        chk("tx_c2_wdata", avm_writedata, 32'h000000A5);
        tx_req = 0;
        tick();
        chk("tx_c3_ack", {31'b0, tx_ack}, 32'h1);
        tick();
        chk("tx_c4_ack", {31'b0, tx_ack}, 32'h0);

        // RX only, zero wait
        do_reset();
        status_val = 32'h80; rx_reg = 32'h0000003C; rx_req = 1;
        tick();
        chk("rx_c1_addr", {27'b0, avm_address}, 32'h8);
        tick();
        chk("rx_c2_addr", {27'b0, avm_address}, 32'h0);
        chk("rx_c2_read", {31'b0, avm_read}, 32'h1);
        rx_req = 0;
        tick();
        chk("rx_c3_valid", {31'b0, rx_valid}, 32'h1);
        chk("rx_c3_data", {24'b0, rx_data}, 32'h3C);
        rx_reg = 32'h00000099;
        tick(); tick();
        chk("rx_c5_hold", {24'b0, rx_data}, 32'h3C);

        // both requesting, both ready
        do_reset();
        status_val = 32'hC0; tx_data = 8'h11; rx_reg = 32'h22;
        tx_req = 1; rx_req = 1;
        repeat (16) tick();
        chk("rr_count_ge4", {31'b0, ord.size() >= 4}, 32'h1);
        if (ord.size() >= 4) begin
            chk("rr_order0", ord[0], 0);
            chk("rr_order1", ord[1], 1);
            chk("rr_order2", ord[2], 0);
            chk("rr_order3", ord[3], 1);
        end
        tx_req = 0; rx_req = 0;
        repeat (6) tick();

        // not-ready polls
        do_reset();
        status_val = 32'h40; nr_polls = 3; tx_data = 8'h33; tx_req = 1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (tx_ack) tx_req = 0;
        end
        chk("nr_status_reads", st_reads, 4);
        chk("nr_writes", wr_cnt, 1);
        chk("nr_acks", ack_cnt, 1);
        nr_polls = 0;

        // two wait states on each phase
        do_reset();
        stall_cfg = 2; status_val = 32'h40; tx_data = 8'h5A; tx_req = 1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c <= 3) begin
                chk("st_poll_addr", {27'b0, avm_address}, 32'h8);
                chk("st_poll_read", {31'b0, avm_read}, 32'h1);
            end else if (c <= 6) begin
                tx_req = 0;
                tx_data = 8'hFF;
                chk("st_xfer_addr", {27'b0, avm_address}, 32'h4);
                chk("st_xfer_write", {31'b0, avm_write}, 32'h1);
                chk("st_xfer_wdata", avm_writedata, 32'h0000005A);
            end
            chk("st_ack_timing", {31'b0, tx_ack}, {31'b0, c == 7});
        end

        // reset while a write is stalled
        do_reset();
        stall_cfg = 3; status_val = 32'h40; tx_data = 8'h77; tx_req = 1;
        repeat (6) tick();
        chk("mr_write_stalled", {31'b0, avm_write}, 32'h1);
        avm_rst = 0; tx_req = 0;
        tick();
        chk("mr_write_drop", {31'b0, avm_write}, 32'h0);
        chk("mr_addr_zero", {27'b0, avm_address}, 32'h0);
        avm_rst = 1;
        repeat (5) tick();
        chk("mr_no_ack", ack_cnt, 0);
        stall_cfg = 0; tx_data = 8'h78; tx_req = 1;
        tick();
        chk("mr_restart_poll", {27'b0, avm_address}, 32'h8);
        chk("mr_restart_read", {31'b0, avm_read}, 32'h1);
        tick();
        tx_req = 0;
        tick();
        chk("mr_restart_ack", {31'b0, tx_ack}, 32'h1);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
